// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage hazard request bundle and hazard-control response.
// master: pipeline/decoder side, slave: pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid_i;
    logic [4:0]       id_rs1_i;
    logic [4:0]       id_rs2_i;
    logic             id_rs1_used_i;
    logic             id_rs2_used_i;
    logic [4:0]       id_wR_i;
    logic             id_rf_we_i;
    logic             id_is_load_i;
    logic             ex_br_taken_i;
    logic             cnt_clr_i;
    logic             pc_stall_o;
    logic             if_id_stall_o;
    logic             if_id_flush_o;
    logic             id_ex_flush_o;
    logic [1:0]       fwd_a_sel_o;
    logic [1:0]       fwd_b_sel_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i,
        output id_rs1_used_i, id_rs2_used_i,
        output id_wR_i, id_rf_we_i, id_is_load_i,
        output ex_br_taken_i, cnt_clr_i,
        input  pc_stall_o, if_id_stall_o,
        input  if_id_flush_o, id_ex_flush_o,
        input  fwd_a_sel_o, fwd_b_sel_o,
        input  stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i,
        input  id_rs1_used_i, id_rs2_used_i,
        input  id_wR_i, id_rf_we_i, id_is_load_i,
        input  ex_br_taken_i, cnt_clr_i,
        output pc_stall_o, if_id_stall_o,
        output if_id_flush_o, id_ex_flush_o,
        output fwd_a_sel_o, fwd_b_sel_o,
        output stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ID/EX hazard controller: EX/MEM/WB scoreboard, stall/flush, fwd selects.
// PIPE_HAZARD_FWD_EN: enable forwarding (else stall on any RAW).
module pipe_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic               clk_i,
    input logic               rst_n_i,
    pipe_hazard_ctrl_if.slave hz
);
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } sb_t;

    sb_t ex_q, mem_q, wb_q, ex_d;
    logic ex_a, ex_b, mem_a, mem_b, wb_a, wb_b;
    logic raw, stall, br, flush_ex;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic sb_unused;

    function automatic logic hit(
        sb_t        e,
        logic [4:0] rs,
        logic       used,
        logic       idv
    );
        return idv && used && e.v && e.we &&
               (e.rd != 5'd0) && (e.rd == rs);
    endfunction

    assign ex_a  = hit(ex_q, hz.id_rs1_i,
                       hz.id_rs1_used_i, hz.id_valid_i);
    assign ex_b  = hit(ex_q, hz.id_rs2_i,
                       hz.id_rs2_used_i, hz.id_valid_i);
    assign mem_a = hit(mem_q, hz.id_rs1_i,
                       hz.id_rs1_used_i, hz.id_valid_i);
    assign mem_b = hit(mem_q, hz.id_rs2_i,
                       hz.id_rs2_used_i, hz.id_valid_i);
    assign wb_a  = hit(wb_q, hz.id_rs1_i,
                       hz.id_rs1_used_i, hz.id_valid_i);
    assign wb_b  = hit(wb_q, hz.id_rs2_i,
                       hz.id_rs2_used_i, hz.id_valid_i);

`ifdef PIPE_HAZARD_FWD_EN
    function automatic logic [1:0] pick(
        logic e,
        logic m,
        logic w
    );
        if (e)      return 2'b01;
        else if (m) return 2'b10;
        else if (w) return 2'b11;
        else        return 2'b00;
    endfunction

    // a load in EX has no data yet, so it can only be resolved by stalling
    assign raw = (ex_a || ex_b) && ex_q.ld;
    assign hz.fwd_a_sel_o = pick(ex_a && !ex_q.ld, mem_a, wb_a);
    assign hz.fwd_b_sel_o = pick(ex_b && !ex_q.ld, mem_b, wb_b);
`else
    // regfile has no write-through, so wait until the writer leaves WB
    assign raw = ex_a || ex_b || mem_a || mem_b || wb_a || wb_b;
    assign hz.fwd_a_sel_o = 2'b00;
    assign hz.fwd_b_sel_o = 2'b00;
`endif

    assign br       = hz.ex_br_taken_i && rst_n_i;
    assign stall    = raw && !br;
    assign flush_ex = stall || br;

    assign hz.pc_stall_o    = stall;
    assign hz.if_id_stall_o = stall;
    assign hz.if_id_flush_o = br;
    assign hz.id_ex_flush_o = flush_ex;
    assign hz.stall_cnt_o   = stall_cnt_q;
    assign hz.flush_cnt_o   = flush_cnt_q;

    assign ex_d = flush_ex ? '0 : {hz.id_valid_i, hz.id_wR_i,
                                   hz.id_rf_we_i, hz.id_is_load_i};
    assign sb_unused = wb_q.ld;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= ex_q;
            wb_q  <= mem_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (hz.cnt_clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (br && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl (CNT_W=4).
// Expected tables differ with PIPE_HAZARD_FWD_EN.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
`ifdef PIPE_HAZARD_FWD_EN
    localparam int RD_CYC = 2;
    localparam int STALLS = 1;
    localparam int ITER   = 20;
    localparam int NV     = 17;
`else
    localparam int RD_CYC = 4;
    localparam int STALLS = 3;
    localparam int ITER   = 7;
    localparam int NV     = 11;
`endif

    typedef struct {
        logic       v;
        logic [4:0] r1;
        logic [4:0] r2;
        logic       u1;
        logic       u2;
        logic [4:0] wr;
        logic       we;
        logic       ld;
        logic       br;
        logic       st;
        logic       fi;
        logic       fe;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    vec_t tbl[NV];
    vec_t idle, lw7, rd7, brv;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .hz      (hz.slave)
    );

    function automatic vec_t mk(
        int v, int r1, int r2, int u1, int u2,
        int wr, int we, int ld, int br,
        int st, int fi, int fe, int fa, int fb
    );
        vec_t x;
        x.v  = 1'(v);
        x.r1 = 5'(r1);
        x.r2 = 5'(r2);
        x.u1 = 1'(u1);
        x.u2 = 1'(u2);
        x.wr = 5'(wr);
        x.we = 1'(we);
        x.ld = 1'(ld);
        x.br = 1'(br);
        x.st = 1'(st);
        x.fi = 1'(fi);
        x.fe = 1'(fe);
        x.fa = 2'(fa);
        x.fb = 2'(fb);
        return x;
    endfunction

    task automatic chk(string nm, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, exp);
    endtask

    task automatic drive(vec_t x);
        hz.id_valid_i    = x.v;
        hz.id_rs1_i      = x.r1;
        hz.id_rs2_i      = x.r2;
        hz.id_rs1_used_i = x.u1;
        hz.id_rs2_used_i = x.u2;
        hz.id_wR_i       = x.wr;
        hz.id_rf_we_i    = x.we;
        hz.id_is_load_i  = x.ld;
        hz.ex_br_taken_i = x.br;
    endtask

    task automatic cyc(vec_t x);
        @(negedge clk);
        drive(x);
    endtask

    task automatic step(vec_t x, string tag);
        cyc(x);
        #1;
        chk({tag, ".pc_stall"}, int'(hz.pc_stall_o), int'(x.st));
        chk({tag, ".ifid_stall"}, int'(hz.if_id_stall_o), int'(x.st));
        chk({tag, ".ifid_flush"}, int'(hz.if_id_flush_o), int'(x.fi));
        chk({tag, ".idex_flush"}, int'(hz.id_ex_flush_o), int'(x.fe));
        chk({tag, ".fwd_a"}, int'(hz.fwd_a_sel_o), int'(x.fa));
        chk({tag, ".fwd_b"}, int'(hz.fwd_b_sel_o), int'(x.fb));
    endtask

    function automatic int sat(int n);
        return (n > 15) ? 15 : n;
    endfunction

    initial begin
        idle = mk(0,0,0,0,0, 0,0,0,0, 0,0,0,0,0);
        lw7  = mk(1,0,0,0,0, 7,1,1,0, 0,0,0,0,0);
        rd7  = mk(1,7,0,1,0, 0,0,0,0, 0,0,0,0,0);
        brv  = mk(0,0,0,0,0, 0,0,0,1, 0,1,1,0,0);
`ifdef PIPE_HAZARD_FWD_EN
        tbl[0]  = mk(1,5,0,1,0, 0,0,0,0, 0,0,0,0,0);
        tbl[1]  = mk(1,1,2,1,1, 5,1,0,0, 0,0,0,0,0);
        tbl[2]  = mk(1,5,5,1,1, 0,0,0,0, 0,0,0,1,1);
        tbl[3]  = mk(1,5,5,1,1, 0,0,0,0, 0,0,0,2,2);
        tbl[4]  = mk(1,5,5,1,1, 0,0,0,0, 0,0,0,3,3);
        tbl[5]  = mk(1,5,5,1,1, 0,0,0,0, 0,0,0,0,0);
        tbl[6]  = mk(1,0,0,0,0, 7,1,1,0, 0,0,0,0,0);
        tbl[7]  = mk(1,3,7,0,1, 0,0,0,0, 1,0,1,0,0);
        tbl[8]  = mk(1,3,7,0,1, 8,1,0,0, 0,0,0,0,2);
        tbl[9]  = mk(1,8,7,1,1, 0,0,0,0, 0,0,0,1,3);
        tbl[10] = mk(1,0,0,0,0, 4,1,1,0, 0,0,0,0,0);
        tbl[11] = mk(1,4,0,1,0, 0,0,0,1, 0,1,1,0,0);
        tbl[12] = mk(1,4,0,1,0, 0,0,0,0, 0,0,0,2,0);
        tbl[13] = mk(1,0,0,0,0, 0,1,0,0, 0,0,0,0,0);
        tbl[14] = mk(1,0,9,1,0, 9,1,0,0, 0,0,0,0,0);
        tbl[15] = mk(1,9,0,0,1, 0,0,0,0, 0,0,0,0,0);
        tbl[16] = mk(0,9,9,1,1, 0,0,0,0, 0,0,0,0,0);
`else
        tbl[0]  = mk(1,5,0,1,0, 0,0,0,0, 0,0,0,0,0);
        tbl[1]  = mk(1,1,2,1,1, 5,1,0,0, 0,0,0,0,0);
        tbl[2]  = mk(1,5,5,1,1, 6,1,0,0, 1,0,1,0,0);
        tbl[3]  = mk(1,5,5,1,1, 6,1,0,0, 1,0,1,0,0);
        tbl[4]  = mk(1,5,5,1,1, 6,1,0,0, 1,0,1,0,0);
        tbl[5]  = mk(1,5,5,1,1, 6,1,0,0, 0,0,0,0,0);
        tbl[6]  = mk(1,6,0,1,0, 0,0,0,1, 0,1,1,0,0);
        tbl[7]  = mk(1,0,0,0,0, 0,1,0,0, 0,0,0,0,0);
        tbl[8]  = mk(1,0,9,1,0, 9,1,0,0, 0,0,0,0,0);
        tbl[9]  = mk(1,9,0,0,1, 0,0,0,0, 0,0,0,0,0);
        tbl[10] = mk(0,9,9,1,1, 0,0,0,0, 0,0,0,0,0);
`endif
        hz.cnt_clr_i = 1'b0;
        drive(idle);

        // reset held over random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            hz.id_valid_i    = 1'($urandom);
            hz.id_rs1_i      = 5'($urandom);
            hz.id_rs2_i      = 5'($urandom);
            hz.id_rs1_used_i = 1'($urandom);
            hz.id_rs2_used_i = 1'($urandom);
            hz.id_wR_i       = 5'($urandom);
            hz.id_rf_we_i    = 1'($urandom);
            hz.id_is_load_i  = 1'($urandom);
            hz.ex_br_taken_i = 1'($urandom);
            hz.cnt_clr_i     = 1'($urandom);
            #1;
            chk("rst.pc_stall", int'(hz.pc_stall_o), 0);
            chk("rst.ifid_stall", int'(hz.if_id_stall_o), 0);
            chk("rst.ifid_flush", int'(hz.if_id_flush_o), 0);
            chk("rst.idex_flush", int'(hz.id_ex_flush_o), 0);
            chk("rst.fwd_a", int'(hz.fwd_a_sel_o), 0);
            chk("rst.fwd_b", int'(hz.fwd_b_sel_o), 0);
            chk("rst.stall_cnt", int'(hz.stall_cnt_o), 0);
            chk("rst.flush_cnt", int'(hz.flush_cnt_o), 0);
        end
        @(negedge clk);
        hz.cnt_clr_i = 1'b0;
        drive(idle);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++)
            step(tbl[i], $sformatf("v%0d", i));
        cyc(idle);
        #1;
        chk("tbl.stall_cnt", int'(hz.stall_cnt_o), STALLS);
        chk("tbl.flush_cnt", int'(hz.flush_cnt_o), 1);
        for (int i = 0; i < 3; i++) cyc(idle);

        // stall counter with saturation
        @(negedge clk);
        hz.cnt_clr_i = 1'b1;
        @(negedge clk);
        hz.cnt_clr_i = 1'b0;
        #1;
        chk("clr.stall_cnt", int'(hz.stall_cnt_o), 0);
        chk("clr.flush_cnt", int'(hz.flush_cnt_o), 0);
        for (int it = 0; it < ITER; it++) begin
            cyc(lw7);
            for (int k = 0; k < RD_CYC; k++) cyc(rd7);
            cyc(idle);
            #1;
            chk($sformatf("sat%0d.stall_cnt", it),
                int'(hz.stall_cnt_o), sat((it + 1) * STALLS));
        end

        // clear issued during a stall cycle
        cyc(lw7);
        cyc(rd7);
        hz.cnt_clr_i = 1'b1;
        #1;
        chk("clrst.pc_stall", int'(hz.pc_stall_o), 1);
        @(negedge clk);
        hz.cnt_clr_i = 1'b0;
        drive(rd7);
        #1;
        chk("clrst.stall_cnt", int'(hz.stall_cnt_o), 0);
        for (int k = 0; k < RD_CYC - 2; k++) cyc(rd7);
        for (int k = 0; k < 3; k++) cyc(idle);

        // flush counter saturation, then clear beats increment
        for (int i = 0; i < 17; i++) begin
            cyc(brv);
            #1;
            chk($sformatf("fl%0d.ifid_flush", i),
                int'(hz.if_id_flush_o), 1);
            chk($sformatf("fl%0d.flush_cnt", i),
                int'(hz.flush_cnt_o), sat(i));
        end
        cyc(brv);
        hz.cnt_clr_i = 1'b1;
        @(negedge clk);
        hz.cnt_clr_i = 1'b0;
        drive(idle);
        #1;
        chk("clrpri.flush_cnt", int'(hz.flush_cnt_o), 0);

        // async reset in the middle of a stall
        cyc(lw7);
        cyc(rd7);
        #1;
        chk("rststall.pre", int'(hz.pc_stall_o), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rststall.pc_stall", int'(hz.pc_stall_o), 0);
        chk("rststall.ifid_stall", int'(hz.if_id_stall_o), 0);
        chk("rststall.idex_flush", int'(hz.id_ex_flush_o), 0);
        @(negedge clk);
        drive(idle);
        rst_n = 1'b1;
        cyc(idle);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
